// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolation select sequencer.
// Boundaries describe the 8x8 prediction block's padded row/column mux map.
package interp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ROWS = 3'd1,
    ST_COLS = 3'd2,
    ST_HALF = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  localparam logic [2:0] PHASE_NONE = 3'd0;
  localparam logic [2:0] PHASE_ROWS = 3'd1;
  localparam logic [2:0] PHASE_COLS = 3'd2;
  localparam logic [2:0] PHASE_HALF = 3'd3;

  localparam int         NUM_PIXEL_DEF = 8;
  localparam int         INT_ROWS      = NUM_PIXEL_DEF + 8;
  localparam int         INT_COLS      = INT_ROWS + NUM_PIXEL_DEF;
  localparam logic [7:0] HALF_A        = 8'd32;
  localparam logic [7:0] HALF_B        = 8'd40;
  localparam logic [7:0] HALF_C        = 8'd48;
  localparam logic [7:0] IDLE_SEL      = 8'hFF;

  // First mux input of the half-sample column group selected by frac_x.
  function automatic logic [7:0] half_base(input logic [1:0] frac_x);
    logic [7:0] base;
    case (frac_x)
      2'd1:    base = 8'(INT_COLS);
      2'd2:    base = HALF_A;
      2'd3:    base = HALF_B;
      default: base = 8'(INT_COLS);
    endcase
    return base;
  endfunction

endpackage

// File: rtl/interp_sel_counter.sv
// Per-phase index counter: advances on enable, clears on phase change,
// flags the terminal value supplied by the current phase.
module interp_sel_counter #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] index,
  output logic         tc
);

  // Clear has priority so a phase change on the last fire restarts at zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      index <= '0;
    end else if (clr) begin
      index <= '0;
    end else if (en) begin
      index <= index + W'(1);
    end else begin
      index <= index;
    end
  end

  assign tc = (index == limit);

endmodule

// File: rtl/interp_sel_sequencer.sv
// Drives sel/s of the interpolation input mux for one prediction block.
// Optional performance counters are enabled with INTERP_SEQ_PERF_CNT_EN.
module interp_sel_sequencer
  import interp_pkg::*;
#(
  parameter int NUM_PIXEL = 8,
  parameter int SEL_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       frac_x,
  input  logic [1:0]       frac_y,
  input  logic             out_ready,
  output logic             busy,
  output logic             sel_valid,
  output logic [SEL_W-1:0] sel,
  output logic [SEL_W-1:0] s,
  output logic             mux_valid,
  output logic             done
`ifdef INTERP_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      blk_cnt
`endif
);

  localparam logic [4:0] ROWS_LAST = 5'(INT_ROWS - 1);
  localparam logic [4:0] PIX_LAST  = 5'(NUM_PIXEL - 1);
  localparam logic [7:0] COLS_BASE = 8'(INT_ROWS);

  state_t     state;
  state_t     state_next;
  logic [1:0] frac_x_q;
  logic [1:0] frac_y_q;
  logic [4:0] index;
  logic [4:0] limit;
  logic       tc;
  logic       active;
  logic       fire;
  logic       phase_change;
  logic [7:0] sel_raw;
  logic [2:0] phase;

  assign active       = (state == ST_ROWS) || (state == ST_COLS) || (state == ST_HALF);
  assign fire         = active && out_ready;
  assign phase_change = (state_next != state);

  interp_sel_counter #(.W(5)) u_counter (
    .clock (clock),
    .reset (reset),
    .en    (fire),
    .clr   (phase_change),
    .limit (limit),
    .index (index),
    .tc    (tc)
  );

  // State, captured phases and the mux-aligned valid/done flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      frac_x_q  <= 2'd0;
      frac_y_q  <= 2'd0;
      mux_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      mux_valid <= fire;
      done      <= fire && tc && (state_next == ST_FIN);
      if ((state == ST_IDLE) && start) begin
        frac_x_q <= frac_x;
        frac_y_q <= frac_y;
      end else begin
        frac_x_q <= frac_x_q;
        frac_y_q <= frac_y_q;
      end
    end
  end

  // Next state and the select word for the current phase.
  always_comb begin
    state_next = state;
    sel_raw    = IDLE_SEL;
    phase      = PHASE_NONE;
    limit      = PIX_LAST;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = ((frac_x == 2'd0) && (frac_y != 2'd0)) ? ST_COLS : ST_ROWS;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ROWS: begin
        phase   = PHASE_ROWS;
        limit   = ROWS_LAST;
        sel_raw = {3'd0, index};
        if (fire && tc) begin
          state_next = ((frac_x_q != 2'd0) && (frac_y_q != 2'd0)) ? ST_HALF : ST_FIN;
        end else begin
          state_next = ST_ROWS;
        end
      end
      ST_COLS: begin
        phase   = PHASE_COLS;
        sel_raw = COLS_BASE + {3'd0, index};
        if (fire && tc) begin
          state_next = ST_FIN;
        end else begin
          state_next = ST_COLS;
        end
      end
      ST_HALF: begin
        phase   = PHASE_HALF;
        sel_raw = half_base(frac_x_q) + {3'd0, index};
        if (fire && tc) begin
          state_next = ST_FIN;
        end else begin
          state_next = ST_HALF;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        busy       = 1'b0;
      end
    endcase
  end

  assign sel_valid = active;
  assign sel       = SEL_W'(sel_raw);
  assign s         = SEL_W'({phase, index});

`ifdef INTERP_SEQ_PERF_CNT_EN
  // Saturating stall counter and wrapping completed-block counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
      blk_cnt   <= 16'd0;
    end else begin
      if (active && !out_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (done) begin
        blk_cnt <= blk_cnt + 16'd1;
      end else begin
        blk_cnt <= blk_cnt;
      end
    end
  end
`endif

endmodule
